// File: rtl/fp_pkg.sv
// Shared binary32 field constants, operand classification and stage-1 payload type
// for the adder alignment front end.
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned BIAS    = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int unsigned GRS_DEF = 3;
    localparam int unsigned SIG_W   = 1 + FRAC_W + GRS_DEF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ClsFinite,
        ClsZero,
        ClsInf,
        ClsNan
    } fp_cls_e;

    // Stage-1 payload: operands already ordered, shift amount precomputed.
    typedef struct packed {
        logic              sign_l;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp_l;
        logic [EXP_W-1:0]  shamt;
        logic [FRAC_W:0]   sig_l;
        logic [FRAC_W:0]   sig_s;
        logic              nan;
        logic              inf;
        logic              zero;
    } align_s1_t;

    // Denormals count as zero unless denormal support is enabled.
    function automatic fp_cls_e fp_classify(input fp32_t x, input logic denorm_en);
        fp_cls_e cls;
        if (x.exp == EXP_MAX) begin
            cls = (x.frac != '0) ? ClsNan : ClsInf;
        end else if (x.exp == '0) begin
            cls = ((x.frac == '0) || !denorm_en) ? ClsZero : ClsFinite;
        end else begin
            cls = ClsFinite;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Barrel right shift with sticky collection: every bit shifted out is ORed into bit 0.
// Amounts at or beyond the width leave only the sticky bit.
module fp_rshift_sticky #(
    parameter int unsigned Width = 27,
    parameter int unsigned AmtW  = 8
) (
    input  logic [Width-1:0] data_i,
    input  logic [AmtW-1:0]  amt_i,
    output logic [Width-1:0] data_o
);

    localparam logic [Width-1:0] Ones = '1;

    logic [Width-1:0] cur;
    logic             sticky;

    always_comb begin
        cur    = data_i;
        sticky = 1'b0;
        if (32'(amt_i) >= Width) begin
            cur    = '0;
            sticky = |data_i;
        end else begin
            // Log stages; each collects the bits it is about to drop.
            for (int k = 0; k < AmtW; k++) begin
                if (amt_i[k]) begin
                    sticky = sticky | (|(cur & ~(Ones << (1 << k))));
                    cur    = cur >> (1 << k);
                end
            end
        end
        data_o = {cur[Width-1:1], cur[0] | sticky};
    end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage binary32 adder front end: unpack/order/classify, then align the smaller
// significand with GRS capture. Define FP_ALIGN_DENORM_EN to keep denormals instead of
// flushing them to signed zero.
module fp_add_align
    import fp_pkg::*;
#(
    parameter int unsigned GRS_W = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [31:0]               a_i,
    input  logic [31:0]               b_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      sign_l_o,
    output logic                      eff_sub_o,
    output logic [EXP_W-1:0]          exp_r_o,
    output logic [FRAC_W+GRS_W:0]     mant_l_o,
    output logic [FRAC_W+GRS_W:0]     mant_s_o,
    output logic                      is_nan_o,
    output logic                      is_inf_o,
    output logic                      is_zero_o
);

    localparam int unsigned SigW = 1 + FRAC_W + GRS_W;

`ifdef FP_ALIGN_DENORM_EN
    localparam logic DenormEn = 1'b1;
`else
    localparam logic DenormEn = 1'b0;
`endif

    // Handshake
    logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic s1_adv, s2_adv;

    assign s2_adv = !s2_v_q || out_ready_i;
    assign s1_adv = !s1_v_q || s2_adv;

    always_comb begin
        s1_v_d = s1_adv ? in_valid_i : s1_v_q;
        s2_v_d = s2_adv ? s1_v_q : s2_v_q;
    end

    // Stage 1: unpack, classify, order by magnitude
    fp32_t            a_op, b_op, l_op, s_op;
    fp_cls_e          a_cls, b_cls;
    logic [EXP_W-1:0] a_eexp, b_eexp, l_eexp, s_eexp;
    logic             a_larger;
    align_s1_t        s1_d, s1_q;

    always_comb begin
        a_op   = fp32_t'(a_i);
        b_op   = fp32_t'(b_i);
        a_cls  = fp_classify(a_op, DenormEn);
        b_cls  = fp_classify(b_op, DenormEn);
        a_eexp = a_op.exp;
        b_eexp = b_op.exp;

        // Denormals either align as exponent 1 or are flushed before the compare.
        if (a_op.exp == '0) begin
            if (DenormEn) begin
                a_eexp = 8'd1;
            end else begin
                a_op.frac = '0;
            end
        end
        if (b_op.exp == '0) begin
            if (DenormEn) begin
                b_eexp = 8'd1;
            end else begin
                b_op.frac = '0;
            end
        end

        a_larger = {a_op.exp, a_op.frac} >= {b_op.exp, b_op.frac};
        l_op     = a_larger ? a_op : b_op;
        s_op     = a_larger ? b_op : a_op;
        l_eexp   = a_larger ? a_eexp : b_eexp;
        s_eexp   = a_larger ? b_eexp : a_eexp;

        s1_d         = '0;
        s1_d.eff_sub = a_op.sign ^ b_op.sign;
        s1_d.sign_l  = l_op.sign;
        s1_d.exp_l   = l_op.exp;
        s1_d.nan     = (a_cls == ClsNan) || (b_cls == ClsNan) ||
                       ((a_cls == ClsInf) && (b_cls == ClsInf) && s1_d.eff_sub);
        s1_d.inf     = !s1_d.nan && ((a_cls == ClsInf) || (b_cls == ClsInf));
        s1_d.zero    = (a_cls == ClsZero) && (b_cls == ClsZero);

        // Specials leave significands and shift at zero so stage 2 emits zeros.
        if (s1_d.inf) begin
            s1_d.sign_l = (a_cls == ClsInf) ? a_op.sign : b_op.sign;
        end else if (s1_d.zero) begin
            s1_d.sign_l = a_op.sign & b_op.sign;
        end else if (!s1_d.nan) begin
            s1_d.shamt = l_eexp - s_eexp;
            s1_d.sig_l = {l_op.exp != '0, l_op.frac};
            s1_d.sig_s = {s_op.exp != '0, s_op.frac};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            if (s1_adv && in_valid_i) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage 2: align the smaller significand
    logic [SigW-1:0] shifted;

    fp_rshift_sticky #(
        .Width (SigW),
        .AmtW  (EXP_W)
    ) u_rshift (
        .data_i ({s1_q.sig_s, {GRS_W{1'b0}}}),
        .amt_i  (s1_q.shamt),
        .data_o (shifted)
    );

    logic             sign_l_q, sign_l_d;
    logic             eff_sub_q, eff_sub_d;
    logic [EXP_W-1:0] exp_r_q, exp_r_d;
    logic [SigW-1:0]  mant_l_q, mant_l_d;
    logic [SigW-1:0]  mant_s_q, mant_s_d;
    logic             nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;

    always_comb begin
        sign_l_d  = s1_q.sign_l;
        eff_sub_d = s1_q.eff_sub;
        exp_r_d   = s1_q.exp_l;
        mant_l_d  = {s1_q.sig_l, {GRS_W{1'b0}}};
        mant_s_d  = shifted;
        nan_d     = s1_q.nan;
        inf_d     = s1_q.inf;
        zero_d    = s1_q.zero;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_v_q    <= 1'b0;
            sign_l_q  <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_r_q   <= '0;
            mant_l_q  <= '0;
            mant_s_q  <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            s2_v_q <= s2_v_d;
            if (s2_adv && s1_v_q) begin
                sign_l_q  <= sign_l_d;
                eff_sub_q <= eff_sub_d;
                exp_r_q   <= exp_r_d;
                mant_l_q  <= mant_l_d;
                mant_s_q  <= mant_s_d;
                nan_q     <= nan_d;
                inf_q     <= inf_d;
                zero_q    <= zero_d;
            end
        end
    end

    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_v_q;
    assign sign_l_o    = sign_l_q;
    assign eff_sub_o   = eff_sub_q;
    assign exp_r_o     = exp_r_q;
    assign mant_l_o    = mant_l_q;
    assign mant_s_o    = mant_s_q;
    assign is_nan_o    = nan_q;
    assign is_inf_o    = inf_q;
    assign is_zero_o   = zero_q;

endmodule
